topk_tracker: RTL and testbench
===============================

Name: topk_tracker

Overview:
- Streaming rank tracker that keeps the K largest samples seen in the current frame, as a sorted register list.
- Generalises the fixed second-largest tracker:
  - parametrised depth K;
  - signed/unsigned compare;
  - optional duplicate suppression;
  - explicit slot-valid bits, so no "0 means empty" aliasing;
  - selectable rank readout;
  - per-frame snapshot with a done pulse.
- Sits after sample capture in the stats path; one insertion per clock, no back-pressure.

Parameters:
- WIDTH, 16: sample width in bits.
- K, 4: number of tracked ranks, K >= 2.
- SIGNED, 0: 1 selects two's-complement compare; 0 selects unsigned compare.
- DISTINCT, 0: 1 ignores a sample equal to any valid entry; 0 stores duplicates as separate ranks.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame restart; empties the live list.
- in_valid  input  1  din is a sample this cycle.
- din  input  WIDTH  sample value.
- in_last  input  1  qualified by in_valid; marks the last sample of the frame.
- rank_sel  input  RSW  rank to read, 0 = largest. RSW = max(1, clog2(K)).
- dout  output  WIDTH  live entry at rank_sel; 0 if that slot is invalid.
- dout_valid  output  1  live slot at rank_sel holds a value.
- count  output  clog2(K+1)  number of valid live entries, 0..K.
- frame_valid  output  1  one-cycle pulse when a frame snapshot updates.
- frame_topk  output  K*WIDTH  snapshot; rank 0 at bits [WIDTH-1:0], rank i at [i*WIDTH +: WIDTH]; invalid ranks read 0.
- frame_count  output  clog2(K+1)  valid entries in the snapshot.

Behaviour:
- Reset (resetn low, asynchronous): all live entries, valid bits, count, frame_topk, frame_count and frame_valid clear to 0 immediately. Rising edges are ignored while resetn is low.
- Live list:
  - slots 0..K-1 are sorted descending;
  - valid slots are always contiguous from slot 0;
  - an invalid slot compares below any value.
- Insertion (in_valid=1):
  - p = first slot that is invalid, or whose value is strictly less than din under the SIGNED rule.
  - Slots p..K-2 shift down one; slot K-1 drops out; din is written to slot p.
  - No p (list full, din <= every entry): no change.
  - Equal values are therefore placed after existing equal entries.
  - DISTINCT=1 with din equal to any valid entry: no change.
  - count saturates at K.
- Latency: a sample accepted at edge N is visible on dout/count after edge N.
  - dout/dout_valid are a combinational mux of the live registers by rank_sel.
  - Back-to-back samples every cycle are supported.
- clear=1 at an edge:
  - The live list is emptied.
  - If in_valid is also 1, din is then inserted as the first entry of the new frame; count=1 after the edge.
  - clear does not touch frame_topk/frame_count and does not pulse frame_valid.
- in_last=1 with in_valid=1 at edge N:
  - The list, including din, is copied to frame_topk/frame_count at edge N.
  - frame_valid is 1 for the cycle after edge N.
  - The live list is emptied at the same edge, so the next sample starts a new frame.
  - This applies even when the sample is dropped (full list or duplicate).
- clear and in_last together: the snapshot holds only din, frame_count=1.
- frame_topk/frame_count hold until the next in_last or reset.
- rank_sel >= K: dout=0, dout_valid=0.
- Arithmetic: compares only, no overflow paths. SIGNED affects ordering only, never the stored bits.
- Mid-frame reset: the frame is discarded and no frame_valid is generated after release.

Test Plan:
- K=4, unsigned. Stream 5,9,3,9,7,1 on consecutive cycles -> live list 9,9,7,5; count=4; rank_sel=1 gives dout=9; rank_sel=3 gives dout=5.
- Same stream with DISTINCT=1 -> live list 9,7,5,3; count=4. Then feed 9 -> list unchanged.
- SIGNED=1. Feed 0xFFFB (-5), 0xFFFE (-2), 0xFFF7 (-9):
  - list 0xFFFE, 0xFFFB, 0xFFF7; count=3;
  - rank_sel=3 gives dout_valid=0, dout=0;
  - repeat with SIGNED=0 -> list 0xFFFE, 0xFFFB, 0xFFF7 ordered unsigned; feed 0x0001 -> stored in slot 3.
- Feed 4, 8, then 2 with in_last:
  - the next cycle has frame_valid=1 for exactly one cycle;
  - frame_topk ranks = 8,4,2,0 and frame_count=3;
  - live count=0;
  - feed 6 -> count=1, and the snapshot is unchanged.
- Live list 20,15. Assert clear with in_valid, din=11 -> list 11; count=1; frame_valid stays 0.
- Full list 9,8,7,6:
  - feed 10 -> 10,9,8,7;
  - feed 0 -> unchanged;
  - drop resetn asynchronously between edges -> all outputs 0 before the next edge, and no frame_valid after release.

Source files
------------

// File: rtl/topk_tracker.sv
// Streaming top-K rank tracker: keeps the K largest samples of a frame as a
// descending register list, with per-frame snapshot and rank readout.

module topk_slot #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] din,
  input  logic             cur_v,
  input  logic [WIDTH-1:0] cur_d,
  input  logic             prev_v,
  input  logic [WIDTH-1:0] prev_d,
  input  logic             prev_gt,
  output logic             gt,
  output logic             eq,
  output logic             nxt_v,
  output logic [WIDTH-1:0] nxt_d
);
  logic above;

  assign above = SIGNED ? ($signed(din) > $signed(cur_d)) : (din > cur_d);
  assign gt    = !cur_v || above;
  assign eq    = cur_v && (din == cur_d);

  // gt is monotonic down the sorted list, so the first gt slot takes din
  // and every later gt slot takes its upstream neighbour.
  always_comb begin
    nxt_v = cur_v;
    nxt_d = cur_d;
    if (gt) begin
      if (prev_gt) begin
        nxt_v = prev_v;
        nxt_d = prev_d;
      end else begin
        nxt_v = 1'b1;
        nxt_d = din;
      end
    end
  end
endmodule

module topk_tracker #(
  parameter int WIDTH    = 16,
  parameter int K        = 4,
  parameter bit SIGNED   = 1'b0,
  parameter bit DISTINCT = 1'b0,
  localparam int RSW     = (K > 2) ? $clog2(K) : 1,
  localparam int CW      = $clog2(K+1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     din,
  input  logic                 in_last,
  input  logic [RSW-1:0]       rank_sel,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic [CW-1:0]        count,
  output logic                 frame_valid,
  output logic [K*WIDTH-1:0]   frame_topk,
  output logic [CW-1:0]        frame_count
);
  logic [K-1:0][WIDTH-1:0] live_d, ins_d, nl_d, snap_d, pd;
  logic [K-1:0]            live_v, base_v, ins_v, nl_v, gt, eq, pv, pg;
  logic                    drop, accept;

  function automatic logic [CW-1:0] popc(input logic [K-1:0] v);
    popc = '0;
    for (int i = 0; i < K; i++) popc = popc + CW'(v[i]);
  endfunction

  assign base_v = clear ? '0 : live_v;

  for (genvar i = 0; i < K; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign pv[i] = 1'b0;
      assign pd[i] = '0;
      assign pg[i] = 1'b0;
    end else begin : g_body
      assign pv[i] = base_v[i-1];
      assign pd[i] = live_d[i-1];
      assign pg[i] = gt[i-1];
    end

    topk_slot #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_slot (
      .din    (din),
      .cur_v  (base_v[i]),
      .cur_d  (live_d[i]),
      .prev_v (pv[i]),
      .prev_d (pd[i]),
      .prev_gt(pg[i]),
      .gt     (gt[i]),
      .eq     (eq[i]),
      .nxt_v  (ins_v[i]),
      .nxt_d  (ins_d[i])
    );

    assign snap_d[i] = nl_v[i] ? nl_d[i] : '0;
  end

  assign drop   = !(|gt) || (DISTINCT && (|eq));
  assign accept = in_valid && !drop;
  assign nl_v   = accept ? ins_v : base_v;
  assign nl_d   = accept ? ins_d : live_d;

  assign count = popc(live_v);

  always_comb begin
    dout       = '0;
    dout_valid = 1'b0;
    if (int'(rank_sel) < K) begin
      dout_valid = live_v[rank_sel];
      dout       = live_v[rank_sel] ? live_d[rank_sel] : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_v      <= '0;
      live_d      <= '0;
      frame_topk  <= '0;
      frame_count <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= in_valid && in_last;
      if (in_valid && in_last) begin
        // snapshot includes this sample; live list restarts for next frame
        frame_topk  <= snap_d;
        frame_count <= popc(nl_v);
        live_v      <= '0;
      end else begin
        live_v <= nl_v;
        live_d <= nl_d;
      end
    end
  end
endmodule

// File: tb/tb_topk_tracker.sv
// Directed bench for topk_tracker: three instances (plain, distinct, signed)
// with expectations queued at drive time and checked after the edge.

module tb_topk_tracker;
  logic        clk, resetn, clear, in_last;
  logic [2:0]  iv;
  logic [15:0] din;
  logic [1:0]  rank_sel;
  logic [15:0] dout_a [3];
  logic        dv_a   [3];
  logic [2:0]  cnt_a  [3];
  logic        fv_a   [3];
  logic [63:0] ftk_a  [3];
  logic [2:0]  fc_a   [3];
  int checks = 0;
  int errors = 0;

  typedef struct {
    string            tag;
    int               inst;
    bit               frame;
    logic [3:0][15:0] d;
    int               cnt;
    logic             fv;
  } exp_t;
  exp_t q[$];

  topk_tracker u0 (
    .clk(clk), .resetn(resetn), .clear(clear), .in_valid(iv[0]), .din(din),
    .in_last(in_last), .rank_sel(rank_sel), .dout(dout_a[0]), .dout_valid(dv_a[0]),
    .count(cnt_a[0]), .frame_valid(fv_a[0]), .frame_topk(ftk_a[0]), .frame_count(fc_a[0]));

  topk_tracker #(.DISTINCT(1'b1)) u1 (
    .clk(clk), .resetn(resetn), .clear(clear), .in_valid(iv[1]), .din(din),
    .in_last(in_last), .rank_sel(rank_sel), .dout(dout_a[1]), .dout_valid(dv_a[1]),
    .count(cnt_a[1]), .frame_valid(fv_a[1]), .frame_topk(ftk_a[1]), .frame_count(fc_a[1]));

  topk_tracker #(.SIGNED(1'b1)) u2 (
    .clk(clk), .resetn(resetn), .clear(clear), .in_valid(iv[2]), .din(din),
    .in_last(in_last), .rank_sel(rank_sel), .dout(dout_a[2]), .dout_valid(dv_a[2]),
    .count(cnt_a[2]), .frame_valid(fv_a[2]), .frame_topk(ftk_a[2]), .frame_count(fc_a[2]));

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic exp_l(input string t, input int i, input logic [15:0] a, b, c, e, input int n);
    exp_t x;
    x.tag = t; x.inst = i; x.frame = 1'b0; x.d = {e, c, b, a}; x.cnt = n; x.fv = 1'b0;
    q.push_back(x);
  endtask

  task automatic exp_f(input string t, input int i, input logic fv, input logic [63:0] tk, input int n);
    exp_t x;
    x.tag = t; x.inst = i; x.frame = 1'b1; x.d = tk; x.cnt = n; x.fv = fv;
    q.push_back(x);
  endtask

  task automatic check_q();
    exp_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      if (!x.frame) begin
        for (int r = 0; r < 4; r++) begin
          rank_sel = 2'(r);
          #1;
          chk($sformatf("%s_d%0d", x.tag, r), 64'(dout_a[x.inst]), (r < x.cnt) ? 64'(x.d[r]) : 64'h0);
          chk($sformatf("%s_v%0d", x.tag, r), 64'(dv_a[x.inst]), (r < x.cnt) ? 64'h1 : 64'h0);
        end
        chk({x.tag, "_cnt"}, 64'(cnt_a[x.inst]), 64'(x.cnt));
      end else begin
        chk({x.tag, "_fv"}, 64'(fv_a[x.inst]), 64'(x.fv));
        chk({x.tag, "_topk"}, ftk_a[x.inst], x.d);
        chk({x.tag, "_fc"}, 64'(fc_a[x.inst]), 64'(x.cnt));
      end
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [15:0] d,
                       input logic l = 1'b0, input logic c = 1'b0);
    @(negedge clk);
    iv = v; din = d; in_last = l; clear = c;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    iv = '0; in_last = 1'b0; clear = 1'b0;
    check_q();
  endtask

  initial begin
    logic [15:0] stream [6];
    stream = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd7, 16'd1};
    resetn = 1'b1; clear = 1'b0; in_last = 1'b0; iv = '0; din = '0; rank_sel = '0;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_l("rst", i, 0, 0, 0, 0, 0);
      exp_f("rst_f", i, 1'b0, 64'h0, 0);
    end
    check_q();
    @(negedge clk) resetn = 1'b1;

    // duplicates kept vs suppressed
    for (int k = 0; k < 6; k++) begin
      drive(3'b011, stream[k]);
      if (k == 5) begin
        exp_l("dup_list", 0, 9, 9, 7, 5, 4);
        exp_l("distinct_list", 1, 9, 7, 5, 3, 4);
      end
      cycle();
    end
    drive(3'b010, 16'd9);
    exp_l("distinct_dup9", 1, 9, 7, 5, 3, 4);
    exp_l("untouched", 0, 9, 9, 7, 5, 4);
    cycle();

    // signed vs unsigned ordering
    drive(3'b000, 16'd0, 1'b0, 1'b1);
    exp_l("clr_all", 0, 0, 0, 0, 0, 0);
    exp_l("clr_all1", 1, 0, 0, 0, 0, 0);
    cycle();
    drive(3'b101, 16'hFFFB); cycle();
    drive(3'b101, 16'hFFFE); cycle();
    drive(3'b101, 16'hFFF7);
    exp_l("s_list", 2, 16'hFFFE, 16'hFFFB, 16'hFFF7, 0, 3);
    exp_l("u_list", 0, 16'hFFFE, 16'hFFFB, 16'hFFF7, 0, 3);
    cycle();
    drive(3'b101, 16'h0001);
    exp_l("s_one", 2, 16'h0001, 16'hFFFE, 16'hFFFB, 16'hFFF7, 4);
    exp_l("u_one", 0, 16'hFFFE, 16'hFFFB, 16'hFFF7, 16'h0001, 4);
    cycle();

    // frame snapshot
    drive(3'b000, 16'd0, 1'b0, 1'b1); cycle();
    drive(3'b001, 16'd4); cycle();
    drive(3'b001, 16'd8); cycle();
    drive(3'b001, 16'd2, 1'b1);
    exp_l("last_live", 0, 0, 0, 0, 0, 0);
    exp_f("last_snap", 0, 1'b1, 64'h0000_0002_0004_0008, 3);
    exp_f("other_nofv", 1, 1'b0, 64'h0, 0);
    cycle();
    drive(3'b001, 16'd6);
    exp_l("after6", 0, 6, 0, 0, 0, 1);
    exp_f("snap_hold", 0, 1'b0, 64'h0000_0002_0004_0008, 3);
    cycle();

    // clear with a sample
    drive(3'b000, 16'd0, 1'b0, 1'b1); cycle();
    drive(3'b001, 16'd20); cycle();
    drive(3'b001, 16'd15); cycle();
    drive(3'b001, 16'd11, 1'b0, 1'b1);
    exp_l("clr_ins", 0, 11, 0, 0, 0, 1);
    exp_f("clr_nofv", 0, 1'b0, 64'h0000_0002_0004_0008, 3);
    cycle();

    // clear together with last
    drive(3'b001, 16'd3, 1'b1, 1'b1);
    exp_l("clrlast_live", 0, 0, 0, 0, 0, 0);
    exp_f("clrlast_snap", 0, 1'b1, 64'h3, 1);
    cycle();

    // full list
    drive(3'b001, 16'd9); cycle();
    drive(3'b001, 16'd8); cycle();
    drive(3'b001, 16'd7); cycle();
    drive(3'b001, 16'd6); cycle();
    drive(3'b001, 16'd10);
    exp_l("full_ins", 0, 10, 9, 8, 7, 4);
    cycle();
    drive(3'b001, 16'd0);
    exp_l("full_drop", 0, 10, 9, 8, 7, 4);
    cycle();

    // last on a dropped duplicate still snapshots
    drive(3'b010, 16'd5); cycle();
    drive(3'b010, 16'd5, 1'b1);
    exp_l("dist_lastlive", 1, 0, 0, 0, 0, 0);
    exp_f("dist_lastdrop", 1, 1'b1, 64'h5, 1);
    cycle();

    // asynchronous reset between edges
    @(negedge clk);
    #5 resetn = 1'b0;
    #1;
    exp_l("arst_live", 0, 0, 0, 0, 0, 0);
    exp_f("arst_f0", 0, 1'b0, 64'h0, 0);
    exp_f("arst_f1", 1, 1'b0, 64'h0, 0);
    check_q();
    @(negedge clk);
    iv = 3'b001; din = 16'd5; in_last = 1'b1;
    @(posedge clk);
    #1;
    iv = '0; in_last = 1'b0;
    exp_l("rst_hold", 0, 0, 0, 0, 0, 0);
    exp_f("rst_hold_f", 0, 1'b0, 64'h0, 0);
    check_q();
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    exp_l("post_rel", 0, 0, 0, 0, 0, 0);
    exp_f("post_rel_f", 0, 1'b0, 64'h0, 0);
    check_q();
    @(posedge clk);
    #1;
    exp_f("post_rel_f2", 0, 1'b0, 64'h0, 0);
    check_q();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
